// File: rtl/uart_mem_ctrl_pkg.sv
// uart_mem_ctrl_pkg: shared state encoding and constants for the UART/memory transfer sequencer
package uart_mem_ctrl_pkg;
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LD_WAIT  = 4'd1,
      LD_WRITE = 4'd2,
      DP_READ  = 4'd3,
      DP_LATCH = 4'd4,
      DP_START = 4'd5,
      DP_ACK   = 4'd6,
      DP_WAIT  = 4'd7,
      DONE     = 4'd8
   } ctrlState_t;
   localparam logic TX_START_ACTIVE = 1'b0;
   localparam int MEM_READ_LATENCY = 1;
endpackage

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: sequences codec words into memory (load) and memory words out to the codec (dump)
module uart_mem_ctrl
   import uart_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  loadStart,
   input  logic                  dumpStart,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] lastAddr,
   output logic                  busy,
   output logic                  done,
   output logic                  rxDropped,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memWrEn,
   output logic [DATA_WIDTH-1:0] memWrData,
   output logic                  memRdEn,
   input  logic [DATA_WIDTH-1:0] memRdData,
   output logic                  txStart,
   input  logic                  txReady,
   output logic [DATA_WIDTH-1:0] codecTxData,
   input  logic                  rxDone,
   input  logic [DATA_WIDTH-1:0] dataFromCodec
);
   ctrlState_t state, stateNext;
   logic [ADDR_WIDTH-1:0] addr, addrNext, lastReg, lastNext;
   logic dropNext;
   logic [DATA_WIDTH-1:0] txDataNext;
   logic inDump;

   assign inDump = state inside {DP_READ, DP_LATCH, DP_START, DP_ACK, DP_WAIT};

   // state, address counter, latched bound, drop flag and transmit word
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state       <= IDLE;
         addr        <= '0;
         lastReg     <= '0;
         rxDropped   <= 1'b0;
         codecTxData <= '0;
      end else begin
         state       <= stateNext;
         addr        <= addrNext;
         lastReg     <= lastNext;
         rxDropped   <= dropNext;
         codecTxData <= txDataNext;
      end
   end

   // next-state decode; abort overrides every transition, including completion
   always_comb begin
      stateNext  = state;
      addrNext   = addr;
      lastNext   = lastReg;
      dropNext   = rxDropped | (inDump & rxDone);
      txDataNext = codecTxData;
      case (state)
         IDLE: if (loadStart || dumpStart) begin
            addrNext  = '0;
            lastNext  = lastAddr;
            dropNext  = 1'b0;
            stateNext = loadStart ? LD_WAIT : DP_READ;
         end
         LD_WAIT:  stateNext = rxDone ? LD_WRITE : LD_WAIT;
         LD_WRITE: begin
            stateNext = (addr == lastReg) ? DONE : LD_WAIT;
            addrNext  = (addr == lastReg) ? addr : addr + 1'b1;
         end
         DP_READ:  stateNext = DP_LATCH;
         DP_LATCH: begin
            txDataNext = memRdData;
            stateNext  = DP_START;
         end
         DP_START: stateNext = txReady ? DP_ACK : DP_START;
         DP_ACK:   stateNext = txReady ? DP_ACK : DP_WAIT;
         DP_WAIT:  if (txReady) begin
            stateNext = (addr == lastReg) ? DONE : DP_READ;
            addrNext  = (addr == lastReg) ? addr : addr + 1'b1;
         end
         DONE:     stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
      if (abort && state != IDLE) stateNext = IDLE;
   end

   assign busy      = state != IDLE;
   assign done      = state == DONE && !abort;
   assign memAddr   = addr;
   assign memWrEn   = state == LD_WRITE && !abort;
   assign memWrData = state == LD_WRITE ? dataFromCodec : '0;
   assign memRdEn   = state == DP_READ && !abort;
   assign txStart   = (state == DP_START && txReady && !abort) ? TX_START_ACTIVE : ~TX_START_ACTIVE;
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: scoreboard bench with memory and codec models for uart_mem_ctrl
module tb_uart_mem_ctrl;
   localparam int DW = 12;
   localparam int AW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
   } wrVec_t;

   logic clk = 1'b0;
   logic rstN = 1'b1;
   logic loadStart = 1'b0, dumpStart = 1'b0, abort = 1'b0;
   logic [AW-1:0] lastAddr = '0;
   logic busy, done, rxDropped, memWrEn, memRdEn, txStart;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWrData, memRdData, codecTxData;
   logic txReady = 1'b1;
   logic rxDone = 1'b0;
   logic [DW-1:0] dataFromCodec = '0;

   logic [DW-1:0] mem [256];
   logic [DW-1:0] expMem [256];
   wrVec_t ldTab [7];
   wrVec_t wrQ [$];
   logic [DW-1:0] txQ [$];
   int total = 0, bad = 0;
   int doneCnt = 0, rdCnt = 0, rdBase = 0, txCnt = 0, txHold = 0, lastRdAddr = 0;
   bit txPend = 1'b0;

   uart_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstN(rstN), .loadStart(loadStart), .dumpStart(dumpStart), .abort(abort),
      .lastAddr(lastAddr), .busy(busy), .done(done), .rxDropped(rxDropped), .memAddr(memAddr),
      .memWrEn(memWrEn), .memWrData(memWrData), .memRdEn(memRdEn), .memRdData(memRdData),
      .txStart(txStart), .txReady(txReady), .codecTxData(codecTxData), .rxDone(rxDone),
      .dataFromCodec(dataFromCodec)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (memWrEn) mem[memAddr] <= memWrData;
      if (memRdEn) memRdData <= mem[memAddr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      wrVec_t e;
      logic [DW-1:0] t;
      if (!rstN) return;
      if (done) doneCnt++;
      if (memWrEn) begin
         check("wrExpected", 32'(wrQ.size() > 0), 1);
         if (wrQ.size() > 0) begin
            e = wrQ.pop_front();
            check("wrAddr", 32'(memAddr), 32'(e.addr));
            check("wrData", 32'(memWrData), 32'(e.data));
         end
      end
      if (memRdEn) begin
         check("rdAddr", 32'(memAddr), 32'(rdCnt - rdBase));
         lastRdAddr = int'(memAddr);
         rdCnt++;
      end
      if (!txStart) begin
         check("txReadyAtStart", 32'(txReady), 1);
         check("txIdleAtStart", 32'(txPend || txHold != 0), 0);
         check("txExpected", 32'(txQ.size() > 0), 1);
         if (txQ.size() > 0) begin
            t = txQ.pop_front();
            check("txData", 32'(codecTxData), 32'(t));
         end
         txCnt++;
         txPend = 1'b1;
      end else if (txPend) begin
         txPend  = 1'b0;
         txReady = 1'b0;
         txHold  = int'($urandom_range(1, 4));
      end else if (txHold > 0) begin
         txHold--;
         if (txHold == 0) txReady = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit ld, input bit dp, input logic [AW-1:0] la);
      loadStart = ld;
      dumpStart = dp;
      lastAddr  = la;
      tick();
      loadStart = 1'b0;
      dumpStart = 1'b0;
      lastAddr  = AW'($urandom);
   endtask

   task automatic sendRx(input logic [DW-1:0] d);
      rxDone = 1'b1;
      dataFromCodec = ~d;
      tick();
      rxDone = 1'b0;
      dataFromCodec = d;
      tick();
   endtask

   task automatic expectWr(input wrVec_t v);
      wrQ.push_back(v);
      expMem[v.addr] = v.data;
   endtask

   task automatic waitDone(input string name, input int budget);
      int d0 = doneCnt;
      int n = 0;
      while (doneCnt == d0 && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(doneCnt - d0), 1);
      tick();
      tick();
      check({name, "Once"}, 32'(doneCnt - d0), 1);
      check({name, "Idle"}, 32'(busy), 0);
      check({name, "WrQ"}, 32'(wrQ.size()), 0);
   endtask

   task automatic checkReset(input string tag);
      check({tag, "Busy"}, 32'(busy), 0);
      check({tag, "Done"}, 32'(done), 0);
      check({tag, "Drop"}, 32'(rxDropped), 0);
      check({tag, "Addr"}, 32'(memAddr), 0);
      check({tag, "WrEn"}, 32'(memWrEn), 0);
      check({tag, "WrData"}, 32'(memWrData), 0);
      check({tag, "RdEn"}, 32'(memRdEn), 0);
      check({tag, "TxStart"}, 32'(txStart), 1);
      check({tag, "TxData"}, 32'(codecTxData), 0);
   endtask

   initial begin
      int t0, r0;
      ldTab = '{'{12'h0A1, 8'd0}, '{12'h0B2, 8'd1}, '{12'h0C3, 8'd2}, '{12'hFFF, 8'd3},
                '{12'h123, 8'd0}, '{12'h456, 8'd1}, '{12'h789, 8'd2}};
      #2 rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1 checkReset("rst");
      rstN = 1'b1;
      tick();

      start(1'b1, 1'b0, 8'd3);
      check("ldBusy", 32'(busy), 1);
      for (int i = 0; i < 4; i++) begin
         expectWr(ldTab[i]);
         sendRx(ldTab[i].data);
      end
      waitDone("load4", 1);

      start(1'b1, 1'b0, 8'd2);
      for (int i = 4; i < 7; i++) begin
         expectWr(ldTab[i]);
         sendRx(ldTab[i].data);
      end
      waitDone("load3", 1);
      t0 = txCnt;
      rdBase = rdCnt;
      for (int i = 4; i < 7; i++) txQ.push_back(ldTab[i].data);
      start(1'b0, 1'b1, 8'd2);
      waitDone("dump3", 400);
      check("dump3Tx", 32'(txCnt - t0), 3);
      check("dump3Rd", 32'(rdCnt - rdBase), 3);
      check("dump3TxQ", 32'(txQ.size()), 0);

      r0 = rdCnt;
      start(1'b1, 1'b1, 8'd0);
      check("bothBusy", 32'(busy), 1);
      repeat (3) tick();
      check("bothNoRead", 32'(rdCnt - r0), 0);
      expectWr('{12'h5A5, 8'd0});
      sendRx(12'h5A5);
      waitDone("bothLoad", 1);

      t0 = doneCnt;
      start(1'b1, 1'b0, 8'd4);
      expectWr('{12'h111, 8'd0});
      sendRx(12'h111);
      expectWr('{12'h222, 8'd1});
      sendRx(12'h222);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abortIdle", 32'(busy), 0);
      sendRx(12'h999);
      repeat (3) tick();
      check("abortNoDone", 32'(doneCnt - t0), 0);
      start(1'b1, 1'b0, 8'd0);
      check("restartAddr", 32'(memAddr), 0);
      expectWr('{12'h333, 8'd0});
      sendRx(12'h333);
      waitDone("restart", 1);

      t0 = txCnt;
      rdBase = rdCnt;
      txQ.push_back(expMem[0]);
      txQ.push_back(expMem[1]);
      start(1'b0, 1'b1, 8'd1);
      check("dropClear", 32'(rxDropped), 0);
      tick();
      sendRx(12'h777);
      check("dropSet", 32'(rxDropped), 1);
      waitDone("dropDump", 400);
      check("dropSticky", 32'(rxDropped), 1);
      check("dropTx", 32'(txCnt - t0), 2);
      start(1'b1, 1'b0, 8'd0);
      check("dropCleared", 32'(rxDropped), 0);
      expectWr('{12'h444, 8'd0});
      sendRx(12'h444);
      waitDone("dropLoad", 1);

      start(1'b1, 1'b0, 8'hFF);
      for (int i = 0; i < 256; i++) begin
         expectWr('{DW'($urandom), AW'(i)});
         sendRx(expMem[i]);
      end
      waitDone("fullLoad", 1);
      t0 = txCnt;
      rdBase = rdCnt;
      for (int i = 0; i < 256; i++) txQ.push_back(expMem[i]);
      start(1'b0, 1'b1, 8'hFF);
      waitDone("fullDump", 6000);
      check("fullTx", 32'(txCnt - t0), 256);
      check("fullRd", 32'(rdCnt - rdBase), 256);
      check("fullLastRd", 32'(lastRdAddr), 255);
      check("fullAddr", 32'(memAddr), 255);

      rdBase = rdCnt;
      for (int i = 0; i < 256; i++) txQ.push_back(expMem[i]);
      start(1'b0, 1'b1, 8'hFF);
      repeat (40) tick();
      check("midBusy", 32'(busy), 1);
      check("midAddrMoved", 32'(memAddr != 0), 1);
      #2 rstN = 1'b0;
      #1 checkReset("midRst");
      txQ.delete();
      txPend = 1'b0;
      txHold = 0;
      txReady = 1'b1;
      @(posedge clk);
      #1 rstN = 1'b1;
      tick();
      check("postRstIdle", 32'(busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
